// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares the 16-bit memory port between the core and one DMA
//             requester, with bounded bursts and a guaranteed CPU slot.
//  Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned CPU_SLOT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ext_halt,
   output logic        cpu_halt,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   input  logic        cpu_rw,
   output logic [15:0] cpu_rdata,
   input  logic        dma_req,
   output logic        dma_gnt,
   input  logic [15:0] dma_addr,
   input  logic [15:0] dma_wdata,
   input  logic        dma_rw,
   output logic [15:0] dma_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rw,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_CPU     = 2'd0,
      ST_HALTING = 2'd1,
      ST_GRANT   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam logic [7:0] c_max_burst = 8'(MAX_BURST);
   localparam logic [7:0] c_cpu_slot  = 8'(CPU_SLOT);

   state_t     state_q, state_d;
   logic [7:0] burst_q, burst_d;
   logic [7:0] cool_q,  cool_d;
   logic       w_sel_dma;
   logic       w_arb_halt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_CPU;
         burst_q <= 8'd0;
         cool_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         cool_q  <= cool_d;
      end
   end

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      cool_d  = cool_q;
      case (state_q)
         ST_CPU: begin
            if (cool_q != 8'd0) cool_d = cool_q - 8'd1;
            if (dma_req && (cool_q == 8'd0)) state_d = ST_HALTING;
         end
         ST_HALTING: begin
            if (dma_req) begin
               state_d = ST_GRANT;
               burst_d = 8'd0;
            end else begin
               state_d = ST_RELEASE;
            end
         end
         ST_GRANT: begin
            if (dma_req) begin
               if (burst_q != 8'hFF) burst_d = burst_q + 8'd1;
               // This cycle performs access burst_q+1; leave once it hits the limit.
               if (({1'b0, burst_q} + 9'd1) >= {1'b0, c_max_burst}) state_d = ST_RELEASE;
            end else begin
               state_d = ST_RELEASE;
            end
         end
         default: begin
            cool_d  = c_cpu_slot;
            state_d = ST_CPU;
         end
      endcase
   end

   assign w_sel_dma  = (state_q == ST_GRANT);
   assign w_arb_halt = (state_q != ST_CPU);

   assign dma_gnt   = w_sel_dma;
   assign cpu_halt  = w_arb_halt | ext_halt;
   assign mem_addr  = w_sel_dma ? dma_addr  : cpu_addr;
   assign mem_wdata = w_sel_dma ? dma_wdata : cpu_wdata;
   // The frozen core may still present a store during hand-back; suppress it.
   assign mem_rw    = w_sel_dma ? dma_rw : ((state_q == ST_RELEASE) ? 1'b0 : cpu_rw);
   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//             compared against a session-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

   localparam int MB = 16;
   localparam int CS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ext_halt = 1'b0;
   logic        cpu_halt;
   logic [15:0] cpu_addr = 16'h0;
   logic [15:0] cpu_wdata = 16'h0;
   logic        cpu_rw = 1'b0;
   logic [15:0] cpu_rdata;
   logic        dma_req = 1'b0;
   logic        dma_gnt;
   logic [15:0] dma_addr = 16'h0;
   logic [15:0] dma_wdata = 16'h0;
   logic        dma_rw = 1'b0;
   logic [15:0] dma_rdata;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rw;
   logic [15:0] mem_rdata = 16'h0;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: a DMA session is handoff -> granted cycles -> give-back.
   bit m_hand, m_dma, m_back;
   int m_used;   // granted accesses performed in this session
   int m_idle;   // completed CPU-owned cycles since the last give-back

   mem_bus_arbiter #(.MAX_BURST(MB), .CPU_SLOT(CS)) dut (
      .clk(clk), .rst(rst), .ext_halt(ext_halt), .cpu_halt(cpu_halt),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rw(dma_rw), .dma_rdata(dma_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rw(mem_rw), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      m_hand = 0; m_dma = 0; m_back = 0; m_used = 0; m_idle = CS;
   endtask

   task automatic check_model();
      logic        e_halt;
      logic        e_rw;
      e_halt = m_hand | m_dma | m_back | ext_halt;
      e_rw   = m_dma ? dma_rw : (m_back ? 1'b0 : cpu_rw);
      chk("gnt",   32'(dma_gnt),   32'(m_dma));
      chk("halt",  32'(cpu_halt),  32'(e_halt));
      chk("addr",  32'(mem_addr),  32'(m_dma ? dma_addr : cpu_addr));
      chk("wdata", 32'(mem_wdata), 32'(m_dma ? dma_wdata : cpu_wdata));
      chk("rw",    32'(mem_rw),    32'(e_rw));
      chk("crd",   32'(cpu_rdata), 32'(mem_rdata));
      chk("drd",   32'(dma_rdata), 32'(mem_rdata));
   endtask

   task automatic tick();
      @(posedge clk);
      if (m_hand) begin
         m_hand = 0;
         if (dma_req) begin m_dma = 1; m_used = 0; end
         else m_back = 1;
      end else if (m_dma) begin
         if (dma_req) m_used++;
         if (!dma_req || m_used == MB) begin m_dma = 0; m_back = 1; end
      end else if (m_back) begin
         m_back = 0; m_idle = 0;
      end else begin
         if (dma_req && m_idle >= CS) m_hand = 1;
         else if (m_idle < 1000) m_idle++;
      end
      #1;
   endtask

   task automatic idle(input int n);
      dma_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); check_model(); tick();
      end
   endtask

   initial begin
      bit tr[70];
      int r1, f1, r2, nh, ng;
      model_reset();

      // Reset values
      cpu_addr = 16'h000F; cpu_rw = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt",  32'(dma_gnt),  32'd0);
      chk("rst_addr", 32'(mem_addr), 32'h000F);
      chk("rst_rw",   32'(mem_rw),   32'd1);
      @(posedge clk); #1 rst = 1'b1;
      cpu_rw = 1'b0;
      @(negedge clk);
      chk("r1_gnt",  32'(dma_gnt),  32'd0);
      chk("r1_halt", 32'(cpu_halt), 32'd0);
      chk("r1_addr", 32'(mem_addr), 32'h000F);
      check_model(); tick();
      idle(3);

      // Short write grant
      cpu_rw = 1'b1; dma_addr = 16'h1234; dma_wdata = 16'hBEEF; dma_rw = 1'b1;
      for (int c = 0; c < 6; c++) begin
         dma_req = (c < 3);
         @(negedge clk);
         check_model();
         chk("sg_halt", 32'(cpu_halt), 32'((c >= 1 && c <= 4) ? 1 : 0));
         chk("sg_gnt",  32'(dma_gnt),  32'((c == 2 || c == 3) ? 1 : 0));
         if (c == 2 || c == 3) begin
            chk("sg_addr", 32'(mem_addr), 32'h1234);
            chk("sg_rw",   32'(mem_rw),   32'd1);
         end
         if (c == 4) chk("sg_relrw", 32'(mem_rw), 32'd0);
         tick();
      end
      cpu_rw = 1'b0; dma_rw = 1'b0;
      idle(8);

      // Burst limit and back-to-back period with request held
      for (int i = 0; i < 70; i++) begin
         dma_req = 1'b1;
         dma_addr = 16'($urandom); cpu_addr = 16'($urandom);
         @(negedge clk); check_model(); tr[i] = dma_gnt; tick();
      end
      r1 = -1; f1 = -1; r2 = -1;
      for (int i = 1; i < 70; i++) begin
         if (tr[i] && !tr[i-1]) begin
            if (r1 < 0) r1 = i;
            else if (r2 < 0 && f1 >= 0) r2 = i;
         end
         if (!tr[i] && tr[i-1] && f1 < 0 && r1 >= 0) f1 = i;
      end
      chk("burst_len", 32'(f1 - r1), 32'(MB));
      chk("gap_len",   32'(r2 - f1), 32'(1 + CS + 1 + 1));
      idle(25);

      // Abort during handoff
      nh = 0; ng = 0;
      for (int c = 0; c < 8; c++) begin
         dma_req = (c == 0);
         @(negedge clk); check_model();
         nh += int'(cpu_halt); ng += int'(dma_gnt);
         tick();
      end
      chk("ab_halt_cyc", 32'(nh), 32'd2);
      chk("ab_gnt_cyc",  32'(ng), 32'd0);
      idle(8);

      // Asynchronous reset in the middle of a grant
      cpu_addr = 16'h0C0C; dma_addr = 16'h7777;
      dma_req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); check_model();
         if (c == 3) begin
            chk("ar_pre_gnt", 32'(dma_gnt), 32'd1);
            #2 rst = 1'b0;
            #1;
            chk("ar_gnt",  32'(dma_gnt),  32'd0);
            chk("ar_addr", 32'(mem_addr), 32'h0C0C);
            chk("ar_halt", 32'(cpu_halt), 32'd0);
            @(posedge clk);
            model_reset();
            #1 rst = 1'b1;
         end else begin
            tick();
         end
      end
      @(negedge clk); check_model(); tick();
      @(negedge clk);
      chk("ar_cool0", 32'(cpu_halt), 32'd1);
      check_model(); tick();
      idle(8);

      // External halt held across a read grant
      ext_halt = 1'b1; dma_rw = 1'b0; mem_rdata = 16'hA5A5; ng = 0;
      for (int c = 0; c < 10; c++) begin
         dma_req = (c < 5);
         @(negedge clk); check_model();
         chk("eh_halt", 32'(cpu_halt), 32'd1);
         if (dma_gnt) begin
            ng++;
            chk("eh_rdata", 32'(dma_rdata), 32'hA5A5);
         end
         tick();
      end
      chk("eh_gnt_cyc", 32'(ng), 32'd4);
      ext_halt = 1'b0;
      idle(8);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) dma_req = ~dma_req;
         ext_halt  = ($urandom_range(7) == 0);
         cpu_addr  = 16'($urandom); cpu_wdata = 16'($urandom); cpu_rw = 1'($urandom);
         dma_addr  = 16'($urandom); dma_wdata = 16'($urandom); dma_rw = 1'($urandom);
         mem_rdata = 16'($urandom);
         @(negedge clk); check_model(); tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
